mem_arbiter: RTL and testbench

- Shares one single-port synchronous block RAM between the instruction-fetch requester (IFetch) and the load/store requester (data memory/IO path).
- Serialises accesses with a small FSM, gives data accesses priority with alternation under contention, and returns results through per-requester req/ack handshakes.
- Sits between the fetch/decode datapath and the unified program/data RAM.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester, data requester and RAM-side
//    signals of the memory arbiter. slave = arbiter view, master = requesters + RAM.
// Latency: none (wires only). Backpressure: req held until the one-cycle ack.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
);
   // instruction-fetch requester
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_ack;
   logic [DATA_WIDTH-1:0] if_rdata;
   // load/store requester
   logic                  dm_req;
   logic                  dm_we;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic                  dm_ack;
   logic [DATA_WIDTH-1:0] dm_rdata;
   // single-port synchronous RAM
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, ram_addr, ram_we, ram_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port sync RAM between instruction fetch and load/store.
// Latency: request seen in IDLE -> ack 2 cycles later; alternating requesters 1 ack / 2 cycles.
// Backpressure: requesters hold req until their one-cycle ack; data wins contention, then alternates.
// Ports: clock_i / reset_i (sync, active-high), bus (mem_arbiter_if.slave: both requesters
//    and the RAM), busy_o (high while an access is in ACCESS or RESP).
module mem_arbiter #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
) (
   input  logic           clock_i,
   input  logic           reset_i,
   mem_arbiter_if.slave   bus,
   output logic           busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  owner_dm_q, owner_dm_d;    // 1 = data access in flight
   logic                  last_dm_q, last_dm_d;      // last grant went to data
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

   logic if_pend, dm_pend, grant, grant_dm;

   // State register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         owner_dm_q <= 1'b0;
         last_dm_q  <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_dm_q <= owner_dm_d;
         last_dm_q  <= last_dm_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Next-state and grant selection
   always_comb begin
      state_d    = state_q;
      owner_dm_d = owner_dm_q;
      last_dm_d  = last_dm_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;

      // In RESP the requester being acked still shows req high; mask it so it
      // cannot be re-granted on its own ack edge.
      if_pend  = bus.if_req & ~((state_q == RESP) & ~owner_dm_q);
      dm_pend  = bus.dm_req & ~((state_q == RESP) &  owner_dm_q);
      grant_dm = dm_pend & (~if_pend | ~last_dm_q);
      grant    = ((state_q == IDLE) | (state_q == RESP)) & (if_pend | dm_pend);

      unique case (state_q)
         IDLE:    state_d = grant ? ACCESS : IDLE;
         ACCESS:  state_d = RESP;
         RESP:    state_d = grant ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase

      if (grant) begin
         owner_dm_d = grant_dm;
         last_dm_d  = grant_dm;
         addr_d     = grant_dm ? bus.dm_addr : bus.if_addr;
         we_d       = grant_dm & bus.dm_we;
         wdata_d    = grant_dm ? bus.dm_wdata : '0;
      end

      // Read data is captured for the owner even on writes; data consumers
      // ignore dm_rdata on a write ack.
      if (state_q == RESP) begin
         if (owner_dm_q) dm_rdata_d = bus.ram_rdata;
         else            if_rdata_d = bus.ram_rdata;
      end
   end

   // Outputs
   always_comb begin
      bus.ram_addr  = addr_q;
      bus.ram_wdata = wdata_q;
      // Reset in the ACCESS cycle must not let a partial write commit.
      bus.ram_we    = (state_q == ACCESS) & we_q & ~reset_i;
      bus.if_ack    = (state_q == RESP) & ~owner_dm_q & ~reset_i;
      bus.dm_ack    = (state_q == RESP) &  owner_dm_q & ~reset_i;
      // RAM data is passed straight through on the ack cycle, then held.
      bus.if_rdata  = bus.if_ack ? bus.ram_rdata : if_rdata_q;
      bus.dm_rdata  = bus.dm_ack ? bus.ram_rdata : dm_rdata_q;
      busy_o        = (state_q == ACCESS) | (state_q == RESP);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural RAM model,
//    per-requester expected-data queues and a table of single-requester vectors.
module tb_mem_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic busy;

   mem_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

   mem_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus     (bus),
      .busy_o  (busy)
   );

   always #5 clock = ~clock;

   // RAM model: read-first, data valid the cycle after the address edge.
   logic [31:0] mem [0:16383];
   logic        pre_we = 1'b0;
   logic [13:0] pre_addr = '0;
   logic [31:0] pre_dat = '0;

   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] <= pre_dat;
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   typedef struct {
      bit          dm;
      bit          we;
      logic [13:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      bit          chk;
      logic [31:0] data;
   } sb_t;

   sb_t sb_if[$];
   sb_t sb_dm[$];
   bit  ack_log[$];
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: every ack pops its requester's queue.
   always @(negedge clock) begin
      sb_t e;
      if (bus.if_ack || bus.dm_ack) begin
         check("ack_exclusive", 32'(bus.if_ack & bus.dm_ack), 32'd0);
         ack_log.push_back(bus.dm_ack);
      end
      if (bus.if_ack) begin
         if (sb_if.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL if_unexpected_ack: got ack, expected none (t=%0t)", $time);
         end else begin
            e = sb_if.pop_front();
            if (e.chk) check("if_rdata", bus.if_rdata, e.data);
         end
      end
      if (bus.dm_ack) begin
         if (sb_dm.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dm_unexpected_ack: got ack, expected none (t=%0t)", $time);
         end else begin
            e = sb_dm.pop_front();
            if (e.chk) check("dm_rdata", bus.dm_rdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_dat = d;
      tick();
      pre_we = 1'b0;
   endtask

   // One requester transaction: push expectation, drive, wait for ack (bounded),
   // check the ACCESS-cycle RAM drive and the latency, then drop req.
   task automatic do_access(input bit dm, input bit we, input logic [13:0] a,
                            input logic [31:0] wd, input logic [31:0] exp,
                            input int exp_lat, input bit chk_idle);
      sb_t e;
      int  lat;
      bit  got;
      e.chk  = !we;
      e.data = exp;
      if (dm) sb_dm.push_back(e); else sb_if.push_back(e);
      tick();
      if (dm) begin
         bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = wd;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = a;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat <= 12) begin
         @(negedge clock);
         if (lat == exp_lat - 1) begin
            check("access_ram_addr", 32'(bus.ram_addr), 32'(a));
            check("access_ram_we", 32'(bus.ram_we), 32'(we));
            check("access_busy", 32'(busy), 32'd1);
         end
         got = dm ? bus.dm_ack : bus.if_ack;
         if (!got) lat++;
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL ack_timeout: no ack after %0d cycles, expected %0d (dm=%0d)", lat, exp_lat, dm);
      end else begin
         check("latency", 32'(lat), 32'(exp_lat));
         check("resp_busy", 32'(busy), 32'd1);
         check("resp_ram_we", 32'(bus.ram_we), 32'd0);
      end
      tick();
      if (dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
      if (chk_idle) begin
         @(negedge clock);
         check("idle_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t vecs[8];

   initial begin
      vecs[0] = '{dm: 1'b0, we: 1'b0, addr: 14'd5,     wdata: 32'h0,        rdata: 32'h2402000A};
      vecs[1] = '{dm: 1'b1, we: 1'b1, addr: 14'h10,    wdata: 32'hDEADBEEF, rdata: 32'h0};
      vecs[2] = '{dm: 1'b1, we: 1'b0, addr: 14'h10,    wdata: 32'h0,        rdata: 32'hDEADBEEF};
      vecs[3] = '{dm: 1'b0, we: 1'b0, addr: 14'h10,    wdata: 32'h0,        rdata: 32'hDEADBEEF};
      vecs[4] = '{dm: 1'b1, we: 1'b1, addr: 14'h3FFF,  wdata: 32'h0BADF00D, rdata: 32'h0};
      vecs[5] = '{dm: 1'b0, we: 1'b0, addr: 14'h3FFF,  wdata: 32'h0,        rdata: 32'h0BADF00D};
      vecs[6] = '{dm: 1'b1, we: 1'b0, addr: 14'h0,     wdata: 32'h0,        rdata: 32'h11111111};
      vecs[7] = '{dm: 1'b1, we: 1'b0, addr: 14'd5,     wdata: 32'h0,        rdata: 32'h2402000A};

      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

      // Preload the RAM while reset holds the arbiter idle.
      reset = 1'b1;
      preload(14'd5,    32'h2402000A);
      preload(14'd0,    32'h11111111);
      preload(14'd7,    32'hAAAA5555);
      preload(14'h20,   32'h55555555);
      for (int i = 0; i < 5; i++) begin
         preload(14'(14'h100 + i), 32'hD0000000 + 32'(i));
         preload(14'(14'h200 + i), 32'h10000000 + 32'(i));
      end

      // Reset state
      @(negedge clock);
      check("rst_if_ack",    32'(bus.if_ack), 32'd0);
      check("rst_dm_ack",    32'(bus.dm_ack), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_ram_we",    32'(bus.ram_we), 32'd0);
      check("rst_if_rdata",  bus.if_rdata, 32'd0);
      check("rst_dm_rdata",  bus.dm_rdata, 32'd0);
      check("rst_ram_addr",  32'(bus.ram_addr), 32'd0);
      check("rst_ram_wdata", bus.ram_wdata, 32'd0);
      tick();
      reset = 1'b0;

      // Single-requester vectors (first is the single fetch of RAM[5])
      for (int i = 0; i < 8; i++)
         do_access(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 2, 1'b1);

      // Contention from reset: data first, fetch granted on the data RESP edge.
      do_reset();
      ack_log.delete();
      fork
         do_access(1'b1, 1'b0, 14'h10, 32'h0, 32'hDEADBEEF, 2, 1'b0);
         do_access(1'b0, 1'b0, 14'd5,  32'h0, 32'h2402000A, 4, 1'b0);
      join
      check("contention_acks", 32'(ack_log.size()), 32'd2);
      if (ack_log.size() == 2) check("contention_dm_first", 32'(ack_log[0]), 32'd1);
      repeat (3) tick();

      // Sustained contention: both re-request right after each ack.
      ack_log.delete();
      fork
         begin
            for (int i = 0; i < 5; i++)
               do_access(1'b1, 1'b0, 14'(14'h100 + i), 32'h0, 32'hD0000000 + 32'(i), 2, 1'b0);
         end
         begin
            for (int j = 0; j < 5; j++)
               do_access(1'b0, 1'b0, 14'(14'h200 + j), 32'h0, 32'h10000000 + 32'(j),
                         (j == 0) ? 4 : 2, 1'b0);
         end
      join
      check("sustained_acks", 32'(ack_log.size()), 32'd10);
      for (int k = 1; k < ack_log.size(); k++)
         check("sustained_alternate", 32'(ack_log[k] != ack_log[k-1]), 32'd1);
      repeat (3) tick();

      // Reset during the ACCESS cycle of a write.
      tick();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 14'h20; bus.dm_wdata = 32'h12345678;
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("abort_ram_we", 32'(bus.ram_we), 32'd0);
      check("abort_dm_ack", 32'(bus.dm_ack), 32'd0);
      tick();
      reset = 1'b0;
      bus.dm_req = 1'b0;
      bus.dm_we = 1'b0;
      @(negedge clock);
      check("abort_busy",     32'(busy), 32'd0);
      check("abort_dm_ack2",  32'(bus.dm_ack), 32'd0);
      check("abort_ram_we2",  32'(bus.ram_we), 32'd0);
      check("abort_dm_rdata", bus.dm_rdata, 32'd0);
      check("abort_if_rdata", bus.if_rdata, 32'd0);
      check("abort_ram_addr", 32'(bus.ram_addr), 32'd0);
      check("abort_mem",      mem[14'h20], 32'h55555555);
      repeat (3) tick();

      // Idle hold after a fetch of 0xAAAA5555.
      do_access(1'b0, 1'b0, 14'd7, 32'h0, 32'hAAAA5555, 2, 1'b1);
      repeat (20) begin
         @(negedge clock);
         check("hold_if_rdata", bus.if_rdata, 32'hAAAA5555);
         check("hold_acks",     32'(bus.if_ack | bus.dm_ack), 32'd0);
         check("hold_busy",     32'(busy), 32'd0);
         check("hold_ram_we",   32'(bus.ram_we), 32'd0);
      end

      check("sb_if_left", 32'(sb_if.size()), 32'd0);
      check("sb_dm_left", 32'(sb_dm.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
